// File: rtl/mem_req_arbiter_if.sv
// Bundle of fetch, load/store and shared-memory handshake signals around mem_req_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding core and memory.
interface mem_req_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        inst_cancel;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
  );

  modport master (
    output inst_req, inst_addr, inst_cancel,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares one in-order memory port between instruction fetch and load/store, routing responses by owner FIFO.
// Define MEM_REQ_ARB_RR_EN for round-robin tie-break; otherwise data has fixed priority over fetch.
module mem_req_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic             clk,
  input  logic             reset,
  mem_req_arbiter_if.slave bus
);

  localparam int               PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [2:0]       CNT_MAX  = 3'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

  state_t                     state, state_nxt;
  logic [2:0]                 count;
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [MAX_OUTSTANDING-1:0] fifo_data;   // owner per slot: 1 = data, 0 = fetch
  logic [MAX_OUTSTANDING-1:0] fifo_disc;
  logic                       full, req, grant_data, sel_data;
  logic                       push, pop, head_data, head_disc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full = (count == CNT_MAX);

`ifdef MEM_REQ_ARB_RR_EN
  // Set means data wins the next tie; it flips to favour whoever was not just accepted.
  logic prio_data;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     prio_data <= 1'b1;
    else if (push) prio_data <= ~grant_data;
  end
  assign sel_data = bus.data_req & (~bus.inst_req | prio_data);
`else
  assign sel_data = bus.data_req;
`endif

  always_comb begin
    state_nxt  = state;
    req        = 1'b0;
    grant_data = 1'b0;
    case (state)
      IDLE: begin
        req        = (bus.inst_req | bus.data_req) & ~full;
        grant_data = sel_data;
        if (req && !bus.mem_addr_ok) state_nxt = grant_data ? HOLD_D : HOLD_I;
      end
      HOLD_I: begin
        req = 1'b1;
        if (bus.mem_addr_ok) state_nxt = IDLE;
      end
      HOLD_D: begin
        req        = 1'b1;
        grant_data = 1'b1;
        if (bus.mem_addr_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are forced low while reset is asserted, without waiting for a clock.
  assign bus.mem_req   = req & ~reset;
  assign push          = bus.mem_req & bus.mem_addr_ok;
  assign pop           = bus.mem_data_ok & (count != 3'd0) & ~reset;
  assign head_data     = fifo_data[rd_ptr];
  assign head_disc     = fifo_disc[rd_ptr];

  assign bus.inst_addr_ok = push & ~grant_data;
  assign bus.data_addr_ok = push & grant_data;
  assign bus.data_data_ok = pop & head_data;
  assign bus.inst_data_ok = pop & ~head_data & ~head_disc;
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;

  assign bus.mem_wr    = grant_data & bus.data_wr;
  assign bus.mem_size  = grant_data ? bus.data_size  : 2'd2;
  assign bus.mem_wstrb = grant_data ? bus.data_wstrb : 4'h0;
  assign bus.mem_addr  = grant_data ? bus.data_addr  : bus.inst_addr;
  assign bus.mem_wdata = grant_data ? bus.data_wdata : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 3'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_data <= '0;
      fifo_disc <= '0;
    end else begin
      state <= state_nxt;
      count <= count + {2'b00, push} - {2'b00, pop};
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      // The popped head was already delivered above; marking its slot is harmless.
      if (bus.inst_cancel) fifo_disc <= fifo_disc | ~fifo_data;
      if (push) begin
        fifo_data[wr_ptr] <= grant_data;
        fifo_disc[wr_ptr] <= bus.inst_cancel & ~grant_data;
      end
    end
  end

endmodule
